// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: sync + glitch filter, 11-bit frame FSM, scan-code FIFO, sticky errors.
// Latency: code visible one cycle after the stop-bit fall; full FIFO drops new codes unless popped that cycle.
module ps2_rx_fifo #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_US  = 100,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [7:0]                    rx_code,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic [3:0]                    err_flags,
    input  logic                          err_clr
);

    localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Line index 0 is the PS/2 clock, index 1 is PS/2 data.
    logic [1:0] raw;
    logic [1:0] sync1_q, sync2_q, filt_q, filt_d;
    logic [7:0] fcnt_q [2];
    logic [7:0] fcnt_d [2];
    logic       clk_prev_q;
    logic       fall, din;

    assign raw = {ps2_data, ps2_clk};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_d[i] = filt_q[i];
            fcnt_d[i] = 8'd0;
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == 8'(FILTER_LEN - 1)) filt_d[i] = sync2_q[i];
                else                                 fcnt_d[i] = fcnt_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            filt_q     <= 2'b11;
            clk_prev_q <= 1'b1;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= 8'd0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            clk_prev_q <= filt_q[0];
            for (int i = 0; i < 2; i++) fcnt_q[i] <= fcnt_d[i];
        end
    end

    assign fall = clk_prev_q & ~filt_q[0];
    assign din  = filt_q[1];

    state_t        state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          busy_q;
    logic          push, set_par, set_frm, set_tmo;

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        tmo_d    = tmo_q;
        push     = 1'b0;
        set_par  = 1'b0;
        set_frm  = 1'b0;
        set_tmo  = 1'b0;
        if (state_q == S_IDLE) begin
            if (fall) begin
                if (!din) begin
                    state_d  = S_DATA;
                    bitcnt_d = 3'd0;
                    tmo_d    = '0;
                end else begin
                    set_frm = 1'b1;
                end
            end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            // Expiry beats a coincident fall: the stalled frame is dropped outright.
            set_tmo = 1'b1;
            state_d = S_IDLE;
            tmo_d   = '0;
        end else if (fall) begin
            tmo_d = '0;
            case (state_q)
                S_DATA: begin
                    shreg_d  = {din, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = din;
                    state_d = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                    push    = din & (^{shreg_q, par_q});
                    set_par = ~(^{shreg_q, par_q});
                    set_frm = ~din;
                end
            endcase
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    err_q, err_d;
    logic          full, pop, do_push, ovf;

    always_comb begin
        full     = (count_q == CW'(FIFO_DEPTH));
        pop      = (count_q != '0) && rx_ready;
        do_push  = push && (!full || pop);
        ovf      = push && full && !pop;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(pop);
        err_d    = (err_clr ? 4'b0000 : err_q) | {ovf, set_tmo, set_frm, set_par};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            bitcnt_q <= 3'd0;
            shreg_q  <= 8'd0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 4'b0000;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            tmo_q    <= tmo_d;
            busy_q   <= (state_d != S_IDLE);
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= shreg_q;
    end

    assign rx_valid   = (count_q != '0);
    assign rx_code    = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;
    assign busy       = busy_q;
    assign err_flags  = err_q;

endmodule
